// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - fetch PC, single-outstanding word fetch, static JAL prediction, FWFT instruction queue
module inst_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          IQ_DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        dec_ready,
  output logic        inst_flag,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pred_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int DEPTH = 1 << IQ_DEPTH_LOG;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                  state;
  logic [31:0]             fetch_pc;
  logic [31:0]             q_inst [DEPTH];
  logic [31:0]             q_pc   [DEPTH];
  logic [31:0]             q_pred [DEPTH];
  logic [IQ_DEPTH_LOG-1:0] rd_ptr;
  logic [IQ_DEPTH_LOG-1:0] wr_ptr;
  logic [IQ_DEPTH_LOG:0]   count;

  logic        empty;
  logic        has_room;
  logic        push;
  logic        pop;
  logic [31:0] jal_imm;
  logic [31:0] next_pc;

  // Static prediction on the returning word, plus queue status and handshake qualifiers
  always_comb begin
    jal_imm   = {{11{mc_data[31]}}, mc_data[31], mc_data[19:12], mc_data[20],
                 mc_data[30:21], 1'b0};
    next_pc   = (mc_data[6:0] == 7'b1101111) ? (fetch_pc + jal_imm) : (fetch_pc + 32'd4);
    empty     = (count == '0);
    // count < DEPTH exactly when the extra top bit of count is clear
    has_room  = !count[IQ_DEPTH_LOG];
    inst_flag = !empty && !redirect;
    push      = rdy && !redirect && (state == WAIT) && mc_done;
    pop       = rdy && inst_flag && dec_ready;
    inst      = empty ? 32'h0 : q_inst[rd_ptr];
    inst_pc   = empty ? 32'h0 : q_pc[rd_ptr];
    pred_pc   = empty ? 32'h0 : q_pred[rd_ptr];
  end

  // Queue storage; entries are only read while count says they are live, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= mc_data;
      q_pc[wr_ptr]   <= fetch_pc;
      q_pred[wr_ptr] <= next_pc;
    end
  end

  // Queue pointers and occupancy; redirect flushes and cancels that cycle's push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  // Fetch FSM: one request at a time, registered request outputs, redirect takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mc_req   <= 1'b0;
      mc_addr  <= 32'h0;
    end else if (rdy) begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        // A completion landing in the redirect cycle retires the stale request right away,
        // otherwise the FSM would wait forever in DISCARD for a second mc_done.
        if (state != IDLE && mc_done) begin
          state  <= IDLE;
          mc_req <= 1'b0;
        end else if (state == WAIT) begin
          state <= DISCARD;
        end
      end else begin
        case (state)
          IDLE: begin
            if (has_room) begin
              mc_req  <= 1'b1;
              mc_addr <= fetch_pc;
              state   <= WAIT;
            end
          end
          WAIT: begin
            if (mc_done) begin
              fetch_pc <= next_pc;
              mc_req   <= 1'b0;
              state    <= IDLE;
            end
          end
          DISCARD: begin
            if (mc_done) begin
              mc_req <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            mc_req <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - randomized scoreboard bench for inst_fetcher against a program-order model
module tb_inst_fetcher;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;
  logic        dec_ready;
  logic        inst_flag;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pred_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_fetcher #(.RESET_PC(RESET_PC), .IQ_DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
    .dec_ready(dec_ready), .inst_flag(inst_flag), .inst(inst), .inst_pc(inst_pc),
    .pred_pc(pred_pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int pops    = 0;
  int pushes  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Program semantics: low region is addi except jal +8 at 0x10; high region is hashed
  function automatic void sem(input logic [31:0] a, output logic is_jal, output logic [31:0] imm);
    logic [31:0] h;
    is_jal = 1'b0;
    imm    = 32'd4;
    if (a == 32'h10) begin
      is_jal = 1'b1;
      imm    = 32'd8;
    end else if (a >= 32'h100 && a < 32'hFFFF_FF00) begin
      h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      if (h[31:29] == 3'd0) begin
        is_jal = 1'b1;
        imm    = {{11{h[20]}}, h[20:2], 2'b00};
        if (imm == 32'h0) imm = 32'h40;
      end
    end
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic        j;
    logic [31:0] imm;
    sem(a, j, imm);
    if (j) return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] a);
    logic        j;
    logic [31:0] imm;
    sem(a, j, imm);
    return j ? a + imm : a + 32'd4;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] pred;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] req_log[$];

  task automatic extend();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc     = model_pc;
      e.w      = word_of(model_pc);
      e.pred   = next_of(model_pc);
      exp_q.push_back(e);
      model_pc = e.pred;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc;
    extend();
  endtask

  // Monitor: restart the expected stream on reset/redirect, compare every accepted instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        restart(RESET_PC);
      end else if (rdy && redirect) begin
        restart(redirect_pc);
      end else if (rdy && inst_flag && dec_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.w);
          chk("pred_pc", pred_pc, e.pred);
          pops++;
          extend();
        end
      end else if (!inst_flag && !redirect) begin
        chk("empty_outputs", inst | inst_pc | pred_pc, 32'h0);
      end
    end
  end

  logic        rdy_rand   = 1'b0;
  logic        mem_manual = 1'b0;
  logic        busy;
  logic        stale;
  logic [31:0] cur_addr;
  int          lat;

  // Memory controller model: one request, 0..2 extra cycles latency, frozen by rdy
  initial begin
    mc_done = 1'b0;
    mc_data = 32'h0;
    rdy     = 1'b1;
    busy    = 1'b0;
    stale   = 1'b0;
    lat     = 0;
    forever begin
      @(posedge clk);
      #2;
      rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mem_manual) begin
        busy = 1'b0;
      end else begin
        mc_done = 1'b0;
        if (rst) begin
          busy = 1'b0;
        end else begin
          if (!busy && mc_req) begin
            busy     = 1'b1;
            stale    = 1'b0;
            cur_addr = mc_addr;
            lat      = $urandom_range(0, 2);
            req_log.push_back(mc_addr);
          end
          if (busy && rdy) begin
            if (redirect) begin
              stale = 1'b1;
            end else if (lat == 0) begin
              mc_done = 1'b1;
              mc_data = word_of(cur_addr);
              busy    = 1'b0;
              if (!stale) pushes++;
            end else begin
              lat--;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] v;
    v = (req_log.size() > idx) ? req_log[idx] : 32'hDEAD_BEEF;
    chk(name, v, exp);
  endtask

  task automatic hold_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    repeat (6) tick();
    redirect = 1'b0;
  endtask

  // Stimulus: directed scenarios, then randomized traffic with redirects and resets
  initial begin
    int r;
    int found;
    int pops_mark;
    rst         = 1'b1;
    dec_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    tick();
    tick();
    chk("rst_mc_req", {31'h0, mc_req}, 32'h0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_inst_flag", {31'h0, inst_flag}, 32'h0);
    chk("rst_outputs", inst | inst_pc | pred_pc, 32'h0);

    // Straight-line fetch from reset, including the jal at 0x10
    req_log.delete();
    rst = 1'b0;
    repeat (60) tick();
    chk_log("seq_req0", 0, 32'h0);
    chk_log("seq_req1", 1, 32'h4);
    chk_log("seq_req2", 2, 32'h8);
    chk_log("seq_req3", 3, 32'hC);
    chk_log("seq_req4", 4, 32'h10);
    chk_log("seq_req5_jal", 5, 32'h18);
    chk("seq_pops", {31'h0, pops >= 10}, 32'h1);

    // Stall the decoder: queue fills to four entries and requests stop
    dec_ready = 1'b0;
    hold_redirect(32'h0);
    req_log.delete();
    pushes = 0;
    repeat (30) tick();
    chk("stall_pushes", pushes, 32'd4);
    chk("stall_mc_req", {31'h0, mc_req}, 32'h0);
    chk("stall_flag", {31'h0, inst_flag}, 32'h1);
    dec_ready = 1'b1;
    repeat (30) tick();
    chk_log("stall_req3", 3, 32'hC);
    chk_log("stall_resume", 4, 32'h10);
    chk_log("stall_skip14", 5, 32'h18);

    // Redirect while waiting on 0x20
    hold_redirect(32'h0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (mc_req && mc_addr == 32'h20) found = 1;
    end
    chk("wait20_reached", found, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    req_log.delete();
    chk("redir_flag", {31'h0, inst_flag}, 32'h0);
    chk("redir_discard_req", {31'h0, mc_req}, 32'h1);
    repeat (20) tick();
    chk_log("redir_req0", 0, 32'h100);

    // Reset in the middle of an outstanding request; its late completion must be ignored
    mem_manual = 1'b1;
    mc_done    = 1'b0;
    found      = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (mc_req) found = 1;
    end
    chk("midwait_reached", found, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_flag", {31'h0, inst_flag}, 32'h0);
    chk("mrst_mc_req", {31'h0, mc_req}, 32'h0);
    mc_done = 1'b1;
    mc_data = 32'h0080_006F;
    tick();
    mc_done = 1'b0;
    chk("mrst_refetch_req", {31'h0, mc_req}, 32'h1);
    chk("mrst_refetch_addr", mc_addr, RESET_PC);
    chk("mrst_late_ignored", {31'h0, inst_flag}, 32'h0);
    req_log.delete();
    mem_manual = 1'b0;
    repeat (30) tick();
    chk_log("mrst_req0", 0, RESET_PC);

    // Randomized traffic: decoder backpressure, rdy stalls, redirects (incl. wrap) and resets
    pops_mark = pops;
    rdy_rand  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      dec_ready = ($urandom_range(0, 2) != 0);
      redirect  = 1'b0;
      rst       = 1'b0;
      r = $urandom_range(0, 199);
      if (r < 3) begin
        redirect = 1'b1;
        case ($urandom_range(0, 2))
          0:       redirect_pc = $urandom & 32'h0000_0FFC;
          1:       redirect_pc = 32'hFFFF_FFF0;
          default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end else if (r == 3) begin
        rst = 1'b1;
      end
    end
    rst       = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b1;
    rdy_rand  = 1'b0;
    repeat (20) tick();
    chk("random_pops", {31'h0, (pops - pops_mark) >= 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
